fpnew_norm_stage: RTL

- Pipelined normalization stage directly upstream of the FP rounding stage in the versacore FP datapath.
- Takes an unnormalized magnitude from the adder/FMA core and left-shifts it by its leading-zero count; adjusts the biased exponent.
- Produces the packed {exponent, mantissa} absolute value, the round/sticky pair {RS}, sign, rounding mode and effective-subtraction flag the rounder consumes.
- One register stage with valid/ready handshake and flush.

---
 rtl/fpnew_pkg_versacore.sv | 35 +++
 rtl/fpnew_norm_stage_if.sv | 47 ++++
 rtl/fpnew_norm_lzc.sv | 25 ++
 rtl/fpnew_norm_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg_versacore.sv
// Shared versacore FP package: rounding modes, the normalization-stage result
// bundle and exponent-format helpers.
package fpnew_pkg_versacore;

    // IEEE-754 rounding modes as encoded in the frm CSR.
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    // Width of the packed {exp, mantissa} field carried in norm_result_t.
    // Sized for the binary32 datapath; narrower formats are zero-extended.
    localparam int unsigned NormAbsWidth = 31;

    // Everything the rounder needs from the normalization stage except the tag.
    typedef struct packed {
        logic [NormAbsWidth-1:0] abs;
        logic [1:0]              rs;
        logic                    sign;
        logic                    eff_sub;
        roundmode_e              rnd_mode;
        logic                    of;
        logic                    uf;
    } norm_result_t;

    // Exponent bias of an IEEE format with the given exponent field width.
    function automatic int unsigned exp_bias(input int unsigned exp_width);
        return (32'd1 << (exp_width - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fpnew_norm_stage_if.sv
// Handshake and data bundle between the adder/FMA core, the normalization
// stage and the rounder. The stage connects through the slave modport; the
// master modport is the view of whatever drives and consumes it.
interface fpnew_norm_stage_if #(
    parameter int unsigned ExpWidth = 8,
    parameter int unsigned ManWidth = 23,
    parameter int unsigned SumWidth = 27,
    parameter int unsigned TagWidth = 4
);
    import fpnew_pkg_versacore::*;

    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [SumWidth-1:0]          sum_i;
    logic [ExpWidth+1:0]          exp_i;
    logic                         sign_i;
    logic                         eff_sub_i;
    roundmode_e                   rnd_mode_i;
    logic [TagWidth-1:0]          tag_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [ExpWidth+ManWidth-1:0] abs_value_o;
    logic [1:0]                   round_sticky_o;
    logic                         sign_o;
    logic                         eff_sub_o;
    roundmode_e                   rnd_mode_o;
    logic [TagWidth-1:0]          tag_o;
    logic                         of_o;
    logic                         uf_o;

    modport slave (
        input  in_valid_i, sum_i, exp_i, sign_i, eff_sub_i, rnd_mode_i, tag_i,
        output in_ready_o,
        output out_valid_o, abs_value_o, round_sticky_o, sign_o, eff_sub_o,
        output rnd_mode_o, tag_o, of_o, uf_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i, sum_i, exp_i, sign_i, eff_sub_i, rnd_mode_i, tag_i,
        input  in_ready_o,
        input  out_valid_o, abs_value_o, round_sticky_o, sign_o, eff_sub_o,
        input  rnd_mode_o, tag_o, of_o, uf_o,
        output out_ready_i
    );

endinterface

// File: rtl/fpnew_norm_lzc.sv
// Combinational leading-zero counter. cnt_o is the number of zeros above the
// most significant set bit; empty_o flags an all-zero input (cnt_o is 0 then).
module fpnew_norm_lzc #(
    parameter int unsigned Width    = 27,
    parameter int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    // Scan upward so the highest set bit is the last one to update the count.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = 0; i < int'(Width); i++) begin
            if (in_i[i]) begin
                cnt_o   = CntWidth'(int'(Width) - 1 - i);
                empty_o = 1'b0;
            end else begin
            end
        end
    end

endmodule

// File: rtl/fpnew_norm_stage.sv
// Normalization stage ahead of the FP rounder: left-justifies the raw
// magnitude, adjusts the exponent, extracts mantissa/round/sticky and flags
// overflow/underflow, behind a single valid/ready output register.
// Build option: FPNEW_NORM_SUBNORM_EN selects gradual underflow (subnormal
// results); without it, results below the normal range flush to zero.
module fpnew_norm_stage
    import fpnew_pkg_versacore::*;
#(
    parameter int unsigned ExpWidth = 8,
    parameter int unsigned ManWidth = 23,
    parameter int unsigned SumWidth = 27,
    parameter int unsigned TagWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    fpnew_norm_stage_if.slave   bus
);

    localparam int unsigned EW       = ExpWidth + 2;
    localparam int unsigned CntWidth = (SumWidth > 1) ? $clog2(SumWidth) : 1;
    localparam int unsigned RoundIdx = SumWidth - ManWidth - 2;
    // Bits strictly below the round position feed sticky.
    localparam logic [SumWidth-1:0] StickyMask =
        (SumWidth'(1) << RoundIdx) - SumWidth'(1);
    // All-ones biased exponent: anything at or above it is infinity range.
    localparam logic signed [EW-1:0] MaxExp = EW'(2 * exp_bias(ExpWidth) + 1);
    localparam logic signed [EW-1:0] ExpOne = EW'(1);

    logic [CntWidth-1:0]        lzc_s;
    logic                       zero_s;
    logic signed [EW-1:0]       lzc_ext_s;
    logic signed [EW-1:0]       exp_in_s;
    logic signed [EW-1:0]       norm_exp_s;
    logic [SumWidth-1:0]        shifted_s;
    logic                       lost_s;
    logic [ManWidth-1:0]        mant_s;
    logic                       round_s;
    logic                       sticky_s;
    logic                       in_xfer_s;
    norm_result_t               res_s;
`ifdef FPNEW_NORM_SUBNORM_EN
    logic [CntWidth-1:0]        shamt_s;
    logic signed [EW-1:0]       exp_m1_s;
    logic signed [EW-1:0]       rsh_amt_s;
    logic [2*SumWidth-1:0]      ext_s;
`endif

    logic                       valid_r;
    norm_result_t               rslt_r;
    logic [TagWidth-1:0]        tag_r;

    fpnew_norm_lzc #(
        .Width    (SumWidth),
        .CntWidth (CntWidth)
    ) u_lzc (
        .in_i    (bus.sum_i),
        .cnt_o   (lzc_s),
        .empty_o (zero_s)
    );

    assign lzc_ext_s = EW'(lzc_s);
    assign exp_in_s  = bus.exp_i;
    assign in_xfer_s = bus.in_valid_i & bus.in_ready_o;

    // Normalize the magnitude and classify the result into zero/overflow/
    // normal/below-normal before it is captured in the output register.
    always_comb begin
        norm_exp_s = exp_in_s - lzc_ext_s;
        shifted_s  = '0;
        lost_s     = 1'b0;
        res_s      = '0;
`ifdef FPNEW_NORM_SUBNORM_EN
        shamt_s    = lzc_s;
        exp_m1_s   = exp_in_s - ExpOne;
        rsh_amt_s  = '0;
        ext_s      = '0;
        if (exp_in_s < ExpOne) begin
            // Already below the normal range: denormalize to the minimum
            // exponent and keep everything shifted out for the sticky bit.
            if ((ExpOne - exp_in_s) > EW'(SumWidth)) begin
                rsh_amt_s = EW'(SumWidth);
            end else begin
                rsh_amt_s = ExpOne - exp_in_s;
            end
            ext_s      = {bus.sum_i, SumWidth'(0)} >> rsh_amt_s;
            shifted_s  = ext_s[2*SumWidth-1:SumWidth];
            lost_s     = |ext_s[SumWidth-1:0];
            norm_exp_s = '0;
        end else begin
            // Never normalize past exponent 1; what is left is subnormal.
            if (exp_m1_s < lzc_ext_s) begin
                shamt_s = exp_m1_s[CntWidth-1:0];
            end else begin
                shamt_s = lzc_s;
            end
            shifted_s  = bus.sum_i << shamt_s;
            norm_exp_s = exp_in_s - EW'(shamt_s);
        end
`else
        shifted_s = bus.sum_i << lzc_s;
`endif
        mant_s   = shifted_s[SumWidth-2 -: ManWidth];
        round_s  = shifted_s[RoundIdx];
        sticky_s = (|(shifted_s & StickyMask)) | lost_s;

        res_s.sign     = bus.sign_i;
        res_s.eff_sub  = bus.eff_sub_i;
        res_s.rnd_mode = bus.rnd_mode_i;

        if (zero_s) begin
            res_s.abs = '0;
            res_s.rs  = 2'b00;
        end else if (norm_exp_s >= MaxExp) begin
            res_s.abs = NormAbsWidth'({{ExpWidth{1'b1}}, {ManWidth{1'b0}}});
            res_s.rs  = 2'b00;
            res_s.of  = 1'b1;
`ifdef FPNEW_NORM_SUBNORM_EN
        end else if (shifted_s[SumWidth-1]) begin
            res_s.abs = NormAbsWidth'({norm_exp_s[ExpWidth-1:0], mant_s});
            res_s.rs  = {round_s, sticky_s};
        end else begin
            res_s.abs = NormAbsWidth'({{ExpWidth{1'b0}}, mant_s});
            res_s.rs  = {round_s, sticky_s};
            res_s.uf  = round_s | sticky_s;
        end
`else
        end else if (norm_exp_s >= ExpOne) begin
            res_s.abs = NormAbsWidth'({norm_exp_s[ExpWidth-1:0], mant_s});
            res_s.rs  = {round_s, sticky_s};
        end else begin
            res_s.abs = '0;
            res_s.rs  = 2'b00;
            res_s.uf  = 1'b1;
        end
`endif
    end

    // Output register: flush beats a load, a load beats a drain, a stalled
    // result holds until the rounder takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            rslt_r  <= '0;
            tag_r   <= '0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
            rslt_r  <= '0;
            tag_r   <= '0;
        end else if (in_xfer_s) begin
            valid_r <= 1'b1;
            rslt_r  <= res_s;
            tag_r   <= bus.tag_i;
        end else if (bus.out_ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.in_ready_o     = ~valid_r | bus.out_ready_i;
    assign bus.out_valid_o    = valid_r;
    assign bus.abs_value_o    = (ExpWidth + ManWidth)'(rslt_r.abs);
    assign bus.round_sticky_o = rslt_r.rs;
    assign bus.sign_o         = rslt_r.sign;
    assign bus.eff_sub_o      = rslt_r.eff_sub;
    assign bus.rnd_mode_o     = rslt_r.rnd_mode;
    assign bus.tag_o          = tag_r;
    assign bus.of_o           = rslt_r.of;
    assign bus.uf_o           = rslt_r.uf;

endmodule
